st7735_cmd_sequencer: RTL and testbench
=======================================

// Module: st7735_cmd_sequencer
// PURPOSE
//  Sequences the single-byte spi_controller for an ST7735 TFT. Drives panel reset, CS and DC.
//  Replays a fixed power-up init table, then serves a host byte stream with per-byte DC
//  and an end-of-transaction flag. Sits between display logic and spi_controller.
// PARAMETERS
//  CLK_HZ       100_000_000      system clock frequency
//  MS_CYCLES    CLK_HZ/1000      clk cycles per delay tick (bench overrides small)
//  COLMOD_VAL   8'h05            init COLMOD data byte (16 bpp)
//  MADCTL_VAL   8'h00            init MADCTL data byte
//  TIMEOUT_CYC  4096             spi_done watchdog limit (used only with macro)
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  synchronous reset, active-low
//  s_valid    in   1  host byte valid
//  s_ready    out  1  sequencer accepts host byte this cycle
//  s_data     in   8  host byte
//  s_dc       in   1  0=command, 1=data
//  s_last     in   1  release CS after this byte
//  init_done  out  1  init table complete; sticky until reset
//  err        out  1  sticky SPI timeout flag (0 without macro)
//  spi_start  out  1  one-cycle start pulse to spi_controller
//  spi_data   out  8  byte to spi_controller
//  spi_busy   in   1  spi_controller busy
//  spi_done   in   1  spi_controller byte-complete pulse
//  lcd_cs_n   out  1  panel chip select, active-low
//  lcd_dc     out  1  panel D/C
//  lcd_rst_n  out  1  panel hardware reset, active-low
// BEHAVIOUR
//  Reset values: s_ready=0, init_done=0, err=0, spi_start=0, spi_data=0,
//   lcd_cs_n=1, lcd_dc=0, lcd_rst_n=0. Reset mid-transfer aborts at once; restarts at HWRST_LOW.
//  FSM: HWRST_LOW(10 ticks, lcd_rst_n=0) -> HWRST_WAIT(120 ticks, lcd_rst_n=1) -> INIT_LOAD
//   -> INIT_SEND -> INIT_WAIT -> [INIT_DELAY] -> next entry, or IDLE after last entry.
//   IDLE -> HOST_SEND -> HOST_WAIT -> IDLE.
//  Init table {dc,byte,last,delay_ticks}: C01 L 150 | C11 L 120 | C3A - 0 | D COLMOD_VAL L 0 |
//   C36 - 0 | D MADCTL_VAL L 0 | C29 L 10. delay 0 skips INIT_DELAY.
//  Tick counter: MS_CYCLES-cycle prescaler; delay of N ticks = N*MS_CYCLES cycles exactly.
//  init_done rises in the cycle IDLE is first entered.
//  s_ready=1 only in IDLE with spi_busy=0. s_valid ignored while s_ready=0 (no loss, host holds).
//  Byte send timing, accept/load at edge N: cycle N+1 lcd_cs_n=0, lcd_dc=dc, spi_data=byte.
//   spi_start=1 for cycle N+2 only, issued only if spi_busy=0, else held until spi_busy=0.
//  spi_done seen at edge M: if last, lcd_cs_n=1 from M+1. s_ready may be 1 from M+1.
//   Back-to-back host bytes: s_ready high one cycle per byte.
//  last=0: CS stays low indefinitely awaiting the next byte; DC may change byte to byte.
//  lcd_dc and spi_data are held stable from load until spi_done.
//  spi_done outside INIT_WAIT/HOST_WAIT is ignored.
//  spi_start never asserted while spi_busy=1.
// CONFIGURATION
//  ST7735_SEQ_TIMEOUT_EN defined: a counter starts at spi_start.
//   If TIMEOUT_CYC cycles pass without spi_done: err=1 (sticky), lcd_cs_n=1, FSM -> IDLE
//   (init aborted: init_done stays 0), and a late spi_done is ignored.
//  Undefined: no counter, err tied 0, wait for spi_done forever.
// TESTING
//  rst_n low 5 cycles, MS_CYCLES=10 -> lcd_rst_n low 100 cyc, high 1200 cyc before first spi_start.
//  Init with spi_controller model -> bytes 01,11,3A,05,36,00,29 in order.
//   DC pattern 0,0,0,1,0,1,0; CS high between groups; init_done=1 after 0x29 plus 100 cycles.
//  Host C2A D00 D7F(last) sent back-to-back -> CS low across all 3 bytes, high 1 cycle after the
//   third spi_done; lcd_dc=0,1,1.
//  s_valid held during init -> s_ready=0 throughout; byte sent exactly once after init_done.
//  Hold spi_busy=1 externally -> spi_start stays 0 until busy drops, then one pulse.
//  TIMEOUT_EN, TIMEOUT_CYC=64, suppress spi_done -> err=1 at start+64, lcd_cs_n=1, s_ready=1.
//   Reset mid-byte -> all outputs at reset values next edge.

Source files
------------

// File: rtl/st7735_cmd_sequencer.sv
// ST7735 command sequencer: panel reset, fixed init table replay, then host byte stream to spi_controller.
// Optional spi_done watchdog enabled by defining ST7735_SEQ_TIMEOUT_EN.
module st7735_cmd_sequencer #(
    parameter int         CLK_HZ      = 100_000_000,
    parameter int         MS_CYCLES   = CLK_HZ / 1000,
    parameter logic [7:0] COLMOD_VAL  = 8'h05,
    parameter logic [7:0] MADCTL_VAL  = 8'h00,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_dc,
    input  logic       s_last,
    output logic       init_done,
    output logic       err,
    output logic       spi_start,
    output logic [7:0] spi_data,
    input  logic       spi_busy,
    input  logic       spi_done,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_rst_n
);

    typedef enum logic [3:0] {
        HWRST_LOW, HWRST_WAIT, INIT_LOAD, INIT_SEND, INIT_WAIT, INIT_DELAY,
        IDLE, HOST_SEND, HOST_WAIT
    } state_t;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
        logic       last;
        logic [7:0] delay;
    } entry_t;

    localparam logic [2:0] LAST_IDX = 3'd6;
    localparam int         PRE_W    = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;

    function automatic entry_t init_entry(input logic [2:0] i);
        entry_t e;
        case (i)
            3'd0:    e = '{dc: 1'b0, data: 8'h01,      last: 1'b1, delay: 8'd150};
            3'd1:    e = '{dc: 1'b0, data: 8'h11,      last: 1'b1, delay: 8'd120};
            3'd2:    e = '{dc: 1'b0, data: 8'h3A,      last: 1'b0, delay: 8'd0};
            3'd3:    e = '{dc: 1'b1, data: COLMOD_VAL, last: 1'b1, delay: 8'd0};
            3'd4:    e = '{dc: 1'b0, data: 8'h36,      last: 1'b0, delay: 8'd0};
            3'd5:    e = '{dc: 1'b1, data: MADCTL_VAL, last: 1'b1, delay: 8'd0};
            default: e = '{dc: 1'b0, data: 8'h29,      last: 1'b1, delay: 8'd10};
        endcase
        return e;
    endfunction

    state_t           state, state_nx;
    logic [2:0]       idx, idx_nx;
    entry_t           entry;
    logic [PRE_W-1:0] presc;
    logic [7:0]       ticks, wait_ticks;
    logic             tick, wait_end, timeout, advance;
    logic             start_nx, cs_nx, dc_nx, rstn_nx, last_r, last_nx, done_nx, err_r, err_nx;
    logic [7:0]       data_nx;

    assign entry    = init_entry(idx);
    assign tick     = (presc == PRE_W'(MS_CYCLES - 1));
    assign wait_end = tick && (ticks == wait_ticks - 8'd1);
    assign s_ready  = (state == IDLE) && !spi_busy;
    assign err      = err_r;

    always_comb begin
        case (state)
            HWRST_LOW:  wait_ticks = 8'd10;
            HWRST_WAIT: wait_ticks = 8'd120;
            default:    wait_ticks = entry.delay;
        endcase
    end

    // Tick prescaler restarts on every state change, so an N-tick wait is exactly N*MS_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (!rst_n || state_nx != state) begin
            presc <= '0;
            ticks <= 8'd0;
        end else if (tick) begin
            presc <= '0;
            ticks <= ticks + 8'd1;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

`ifdef ST7735_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WD_W-1:0] wd;

    always_ff @(posedge clk) begin
        if (!rst_n || start_nx)
            wd <= '0;
        else if (state == INIT_WAIT || state == HOST_WAIT)
            wd <= wd + WD_W'(1);
    end

    assign timeout = (wd == WD_W'(TIMEOUT_CYC - 1));
`else
    // No watchdog in this build: the comparison is constant false.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        start_nx = 1'b0;
        data_nx  = spi_data;
        dc_nx    = lcd_dc;
        cs_nx    = lcd_cs_n;
        rstn_nx  = lcd_rst_n;
        last_nx  = last_r;
        done_nx  = init_done;
        err_nx   = err_r;
        advance  = 1'b0;
        case (state)
            HWRST_LOW: begin
                if (wait_end) begin
                    state_nx = HWRST_WAIT;
                    rstn_nx  = 1'b1;
                end
            end
            HWRST_WAIT: begin
                if (wait_end) state_nx = INIT_LOAD;
            end
            INIT_LOAD: begin
                data_nx  = entry.data;
                dc_nx    = entry.dc;
                last_nx  = entry.last;
                cs_nx    = 1'b0;
                state_nx = INIT_SEND;
            end
            INIT_SEND: begin
                if (!spi_busy) begin
                    start_nx = 1'b1;
                    state_nx = INIT_WAIT;
                end
            end
            INIT_WAIT: begin
                if (spi_done) begin
                    if (last_r) cs_nx = 1'b1;
                    if (entry.delay == 8'd0) advance = 1'b1;
                    else state_nx = INIT_DELAY;
                end else if (timeout) begin
                    err_nx   = 1'b1;
                    cs_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            INIT_DELAY: begin
                if (wait_end) advance = 1'b1;
            end
            IDLE: begin
                if (s_valid && !spi_busy) begin
                    data_nx  = s_data;
                    dc_nx    = s_dc;
                    last_nx  = s_last;
                    cs_nx    = 1'b0;
                    state_nx = HOST_SEND;
                end
            end
            HOST_SEND: begin
                if (!spi_busy) begin
                    start_nx = 1'b1;
                    state_nx = HOST_WAIT;
                end
            end
            HOST_WAIT: begin
                if (spi_done) begin
                    if (last_r) cs_nx = 1'b1;
                    state_nx = IDLE;
                end else if (timeout) begin
                    err_nx   = 1'b1;
                    cs_nx    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = HWRST_LOW;
        endcase
        if (advance) begin
            if (idx == LAST_IDX) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end else begin
                idx_nx   = idx + 3'd1;
                state_nx = INIT_LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HWRST_LOW;
            idx       <= 3'd0;
            spi_start <= 1'b0;
            spi_data  <= 8'h00;
            lcd_cs_n  <= 1'b1;
            lcd_dc    <= 1'b0;
            lcd_rst_n <= 1'b0;
            last_r    <= 1'b0;
            init_done <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            spi_start <= start_nx;
            spi_data  <= data_nx;
            lcd_cs_n  <= cs_nx;
            lcd_dc    <= dc_nx;
            lcd_rst_n <= rstn_nx;
            last_r    <= last_nx;
            init_done <= done_nx;
            err_r     <= err_nx;
        end
    end

endmodule

// File: tb/tb_st7735_cmd_sequencer.sv
// Directed bench for st7735_cmd_sequencer with a behavioural spi_controller model.
// Exercises the timeout path too when ST7735_SEQ_TIMEOUT_EN is defined.
module tb_st7735_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_dc = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready, init_done, err, spi_start, lcd_cs_n, lcd_dc, lcd_rst_n;
    logic [7:0] spi_data;
    logic       spi_busy, spi_done;

    always #5 clk = ~clk;

    st7735_cmd_sequencer #(.MS_CYCLES(10), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_dc(s_dc), .s_last(s_last), .init_done(init_done), .err(err), .spi_start(spi_start),
        .spi_data(spi_data), .spi_busy(spi_busy), .spi_done(spi_done), .lcd_cs_n(lcd_cs_n),
        .lcd_dc(lcd_dc), .lcd_rst_n(lcd_rst_n)
    );

    // spi_controller model: busy for 5 cycles per byte, then a done pulse
    logic       hold_busy = 1'b0, suppress = 1'b0, extra_done = 1'b0;
    logic       m_busy = 1'b0, m_done = 1'b0;
    int         m_cnt = 0;
    logic [7:0] log_data [0:31];
    logic       log_dc   [0:31];
    int         log_n = 0;

    assign spi_busy = m_busy | hold_busy;
    assign spi_done = m_done | extra_done;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (spi_start && !spi_busy && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= 4;
            if (log_n < 32) begin
                log_data[log_n] <= spi_data;
                log_dc[log_n]   <= lcd_dc;
                log_n           <= log_n + 1;
            end
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_done <= !suppress;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int   cyc = 0, viol = 0, ready_early = 0, cs_rises = 0, cs_gap = 0, starts = 0;
    logic prev_start = 1'b0, prev_cs = 1'b1, init_phase = 1'b0, burst = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((spi_start && spi_busy) || (spi_start && prev_start)) viol <= viol + 1;
        prev_start <= spi_start;
        if (spi_start) starts <= starts + 1;
        if (init_phase && !init_done && s_ready) ready_early <= ready_early + 1;
        if (init_phase && lcd_cs_n && !prev_cs) cs_rises <= cs_rises + 1;
        prev_cs <= lcd_cs_n;
        if (burst && lcd_cs_n) cs_gap <= cs_gap + 1;
    end

    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic dc, input logic last);
        int n;
        n = 0;
        s_data = d; s_dc = dc; s_last = last; s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", s_ready, 1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0] exp_data;
        logic       exp_dc;
    } init_vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
        logic       last;
        logic [7:0] exp_data;
        logic       exp_dc;
    } host_vec_t;

    init_vec_t init_tab [7];
    host_vec_t host_tab [3];

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t expected end before it", $time);
        $fatal(1, "global timeout");
    end

    initial begin
        int n, m, k, c1, c2, s0;
        init_tab[0] = '{8'h01, 1'b0};
        init_tab[1] = '{8'h11, 1'b0};
        init_tab[2] = '{8'h3A, 1'b0};
        init_tab[3] = '{8'h05, 1'b1};
        init_tab[4] = '{8'h36, 1'b0};
        init_tab[5] = '{8'h00, 1'b1};
        init_tab[6] = '{8'h29, 1'b0};
        host_tab[0] = '{8'h2A, 1'b0, 1'b0, 8'h2A, 1'b0};
        host_tab[1] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
        host_tab[2] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b1};

        // host byte held valid from the start; must not be taken before init_done
        s_valid = 1'b1; s_data = 8'hA5; s_dc = 1'b1; s_last = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_init_done", init_done, 0);
        check("rst_err", err, 0);
        check("rst_spi_start", spi_start, 0);
        check("rst_spi_data", spi_data, 8'h00);
        check("rst_lcd_cs_n", lcd_cs_n, 1);
        check("rst_lcd_dc", lcd_dc, 0);
        check("rst_lcd_rst_n", lcd_rst_n, 0);
        rst_n = 1'b1;
        init_phase = 1'b1;

        n = 0;
        do begin @(posedge clk); #1; n++; end while (!lcd_rst_n && n < 500);
        check("rst_low_cycles", n, 100);
        // 1200 tick cycles, one INIT_LOAD cycle, then start follows the load by two edges
        m = 0;
        do begin @(posedge clk); #1; m++; end while (!spi_start && m < 3000);
        check("rst_high_to_first_start", m, 1202);

        k = 0;
        while (!(log_n == 7 && spi_done) && k < 10000) begin @(negedge clk); k++; end
        c1 = cyc;
        k = 0;
        while (!init_done && k < 500) begin @(negedge clk); k++; end
        c2 = cyc;
        // done is sampled one edge after it is seen, then 100 delay cycles
        check("init_done_after_29", c2 - c1, 101);
        init_phase = 1'b0;
        check("ready_low_during_init", ready_early, 0);
        check("cs_high_between_groups", cs_rises, 5);
        check("init_byte_count", log_n, 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("init_byte_%0d", i), log_data[i], init_tab[i].exp_data);
            check($sformatf("init_dc_%0d", i), log_dc[i], init_tab[i].exp_dc);
        end

        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        k = 0;
        while (!(log_n == 8 && lcd_cs_n && !spi_busy) && k < 100) begin @(negedge clk); k++; end
        check("held_byte_data", log_data[7], 8'hA5);
        check("held_byte_dc", log_dc[7], 1);
        repeat (20) @(negedge clk);
        check("held_byte_once", log_n, 8);

        send_byte(host_tab[0].data, host_tab[0].dc, host_tab[0].last);
        burst = 1'b1;
        send_byte(host_tab[1].data, host_tab[1].dc, host_tab[1].last);
        send_byte(host_tab[2].data, host_tab[2].dc, host_tab[2].last);
        k = 0;
        while (!spi_done && k < 100) begin @(negedge clk); k++; end
        burst = 1'b0;
        check("cs_low_across_burst", cs_gap, 0);
        @(posedge clk); #1;
        check("cs_release_after_last", lcd_cs_n, 1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("host_byte_%0d", i), log_data[8 + i], host_tab[i].exp_data);
            check($sformatf("host_dc_%0d", i), log_dc[8 + i], host_tab[i].exp_dc);
        end

        s0 = starts;
        send_byte(8'h5C, 1'b0, 1'b1);
        hold_busy = 1'b1;
        repeat (20) @(negedge clk);
        check("no_start_while_busy", starts - s0, 0);
        hold_busy = 1'b0;
        repeat (10) @(negedge clk);
        check("one_start_after_busy", starts - s0, 1);
        k = 0;
        while (!(lcd_cs_n && !spi_busy) && k < 100) begin @(negedge clk); k++; end
        check("busy_byte_data", log_data[11], 8'h5C);

        s0 = starts;
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_done_ready", s_ready, 1);
        check("stray_done_cs", lcd_cs_n, 1);
        check("stray_done_no_start", starts - s0, 0);

`ifdef ST7735_SEQ_TIMEOUT_EN
        suppress = 1'b1;
        s0 = starts;
        send_byte(8'h77, 1'b0, 1'b1);
        k = 0;
        while (!spi_start && k < 20) begin @(negedge clk); k++; end
        c1 = cyc;
        k = 0;
        while (!err && k < 200) begin @(negedge clk); k++; end
        c2 = cyc;
        check("timeout_err_delay", c2 - c1, 64);
        check("timeout_cs_high", lcd_cs_n, 1);
        check("timeout_ready", s_ready, 1);
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        repeat (3) @(negedge clk);
        check("late_done_err_sticky", err, 1);
        check("late_done_ready", s_ready, 1);
        check("late_done_no_start", starts - s0, 1);
        suppress = 1'b0;
`else
        check("err_tied_low", err, 0);
`endif

        send_byte(8'hEE, 1'b1, 1'b1);
        k = 0;
        while (!spi_start && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_s_ready", s_ready, 0);
        check("abort_init_done", init_done, 0);
        check("abort_err", err, 0);
        check("abort_spi_start", spi_start, 0);
        check("abort_spi_data", spi_data, 8'h00);
        check("abort_lcd_cs_n", lcd_cs_n, 1);
        check("abort_lcd_dc", lcd_dc, 0);
        check("abort_lcd_rst_n", lcd_rst_n, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!lcd_rst_n && n < 500);
        check("rst_low_after_abort", n, 100);
        check("start_protocol_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
